// File: rtl/alu32_arbiter.sv
// Round-robin valid/ready front end that shares one 32-bit ALU between two requesters.
// Optional per-requester sticky overflow bits are enabled with ALU_ARB_STICKY_OVF_EN.
module alu32_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [2:0]  req0_control,
    input  logic [2:0]  req1_control,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_out,
    output logic        resp_overflow,
    output logic        resp_zero,
    output logic        resp_negative,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_out,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    input  logic        alu_negative
`ifdef ALU_ARB_STICKY_OVF_EN
    ,
    output logic [1:0]  sticky_ovf,
    input  logic [1:0]  ovf_clear
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        inflight_id_q, inflight_id_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_ctl_q, alu_ctl_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [31:0] resp_out_q, resp_out_d;
    logic        resp_ovf_q, resp_ovf_d;
    logic        resp_zero_q, resp_zero_d;
    logic        resp_neg_q, resp_neg_d;

    logic grant;
    logic accept;
    logic resp_fire;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else                          grant = req1_valid;
    end

    assign accept    = (state_q == IDLE) && (req0_valid || req1_valid) && !reset;
    assign resp_fire = (state_q == RESP) && resp_valid_q && resp_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (resp_fire) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output logic: readies are combinational and only for the granted requester
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == IDLE && !reset) begin
            req0_ready = req0_valid && (grant == 1'b0);
            req1_ready = req1_valid && (grant == 1'b1);
        end
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        inflight_id_d = inflight_id_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctl_d     = alu_ctl_q;
        if (accept) begin
            last_grant_d  = grant;
            inflight_id_d = grant;
            alu_a_d       = grant ? req1_A       : req0_A;
            alu_b_d       = grant ? req1_B       : req0_B;
            alu_ctl_d     = grant ? req1_control : req0_control;
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        resp_ovf_d   = resp_ovf_q;
        resp_zero_d  = resp_zero_q;
        resp_neg_d   = resp_neg_q;
        if (state_q == EXEC) begin
            resp_valid_d = 1'b1;
            resp_id_d    = inflight_id_q;
            resp_out_d   = alu_out;
            resp_ovf_d   = alu_overflow;
            resp_zero_d  = alu_zero;
            resp_neg_d   = alu_negative;
        end else if (resp_fire) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            inflight_id_q <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctl_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_out_q    <= '0;
            resp_ovf_q    <= 1'b0;
            resp_zero_q   <= 1'b0;
            resp_neg_q    <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            inflight_id_q <= inflight_id_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctl_q     <= alu_ctl_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_out_q    <= resp_out_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_zero_q   <= resp_zero_d;
            resp_neg_q    <= resp_neg_d;
        end
    end

`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0] sticky_q, sticky_d;
    logic [1:0] sticky_set;

    // Set is OR-ed in after the clear so a same-cycle set wins.
    always_comb begin
        sticky_set = 2'b00;
        if (state_q == EXEC && alu_overflow) sticky_set[inflight_id_q] = 1'b1;
        sticky_d = (sticky_q & ~ovf_clear) | sticky_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sticky_q <= 2'b00;
        else       sticky_q <= sticky_d;
    end

    assign sticky_ovf = sticky_q;
`endif

    assign alu_A         = alu_a_q;
    assign alu_B         = alu_b_q;
    assign alu_control   = alu_ctl_q;
    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_out      = resp_out_q;
    assign resp_overflow = resp_ovf_q;
    assign resp_zero     = resp_zero_q;
    assign resp_negative = resp_neg_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Scoreboard bench for alu32_arbiter with a behavioural ALU hooked to the alu_* ports.
module tb_alu32_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]  req0_control, req1_control;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_out;
    logic        resp_overflow, resp_zero, resp_negative;
    logic [31:0] alu_A, alu_B, alu_out;
    logic [2:0]  alu_control;
    logic        alu_overflow, alu_zero, alu_negative;
`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0]  sticky_ovf, ovf_clear;
`endif

    alu32_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
        .req0_control(req0_control), .req1_control(req1_control),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_overflow(resp_overflow),
        .resp_zero(resp_zero), .resp_negative(resp_negative),
        .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_negative(alu_negative)
`ifdef ALU_ARB_STICKY_OVF_EN
        , .sticky_ovf(sticky_ovf), .ovf_clear(ovf_clear)
`endif
    );

    always #5 clock = ~clock;

    // {overflow, zero, negative, result}; control[1] selects add/sub, else and/or.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        if (c[1]) begin
            if (c[0]) begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end else begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
        end else begin
            r = c[0] ? (a | b) : (a & b);
        end
        return {v, (r == 32'd0), r[31], r};
    endfunction

    always_comb {alu_overflow, alu_zero, alu_negative, alu_out} = alu_f(alu_A, alu_B, alu_control);

    typedef struct {
        logic        id;
        logic [34:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: push on accept, pop on response handshake.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{1'b0, alu_f(req0_A, req0_B, req0_control)});
                grant_log.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{1'b1, alu_f(req1_A, req1_B, req1_control)});
                grant_log.push_back(1);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_id", {63'd0, resp_id}, {63'd0, e.id});
                    chk("sb_res", {29'd0, resp_overflow, resp_zero, resp_negative, resp_out},
                        {29'd0, e.res});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one request, wait for its accept, then drop valid; returns in the EXEC cycle.
    task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c);
        bit ok;
        ok = 0;
        if (id) begin req1_A = a; req1_B = b; req1_control = c; req1_valid = 1'b1; end
        else    begin req0_A = a; req0_B = b; req0_control = c; req0_valid = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                ok = 1;
                break;
            end
        end
        step();
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int base;
        logic [31:0] held;
        reset = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
        req0_control = '0; req1_control = '0;
`ifdef ALU_ARB_STICKY_OVF_EN
        ovf_clear = 2'b00;
`endif
        // Reset state
        @(negedge clock);
        chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp", {29'd0, resp_id, resp_overflow, resp_zero, resp_negative, resp_out}, 64'd0);
        chk("rst_alu", {alu_A, alu_B} | {61'd0, alu_control}, 64'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        step();

        // Single add with latency check
        send(0, 32'd5, 32'd3, 3'b010);
        @(negedge clock);
        chk("lat_exec_valid", {63'd0, resp_valid}, 64'd0);
        chk("alu_regs", {alu_A, 29'd0, alu_control}, {32'd5, 29'd0, 3'b010});
        chk("alu_b", {32'd0, alu_B}, 64'd3);
        @(negedge clock);
        chk("lat_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("add_out", {32'd0, resp_out}, 64'd8);
        chk("add_id_flags", {60'd0, resp_id, resp_overflow, resp_zero, resp_negative}, 64'd0);
        step();

        // Overflow on req0
        send(0, 32'h7FFFFFFF, 32'd1, 3'b010);
        @(negedge clock);
        @(negedge clock);
        chk("ovf_out", {32'd0, resp_out}, 64'h80000000);
        chk("ovf_flags", {61'd0, resp_overflow, resp_zero, resp_negative}, 64'b101);
        step();
`ifdef ALU_ARB_STICKY_OVF_EN
        step();
        chk("sticky_set", {62'd0, sticky_ovf}, 64'b01);
        ovf_clear = 2'b01;
        step();
        ovf_clear = 2'b00;
        @(negedge clock);
        chk("sticky_clr", {62'd0, sticky_ovf}, 64'b00);
        step();
`endif

        // Zero flag on req1
        send(1, 32'd3, 32'd3, 3'b011);
        @(negedge clock);
        @(negedge clock);
        chk("zero_out", {32'd0, resp_out}, 64'd0);
        chk("zero_id_flag", {62'd0, resp_id, resp_zero}, 64'b11);
        step();

        // Tie held for three operations: last_grant is 1, so req0, req1, req0
        base = grant_log.size();
        req0_A = 32'd100; req0_B = 32'd1;  req0_control = 3'b011;
        req1_A = 32'hF0;  req1_B = 32'h0F; req1_control = 3'b001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (grant_log.size() >= base + 3) break;
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (grant_log.size() >= base + 3) begin
            chk("tie_order", {61'd0, grant_log[base][0], grant_log[base+1][0], grant_log[base+2][0]},
                64'b010);
        end else begin
            chk("tie_timeout", 64'd0, 64'd1);
        end
        repeat (4) step();

        // Back-pressure: response frozen, no accept, resume right after handshake
        resp_ready = 1'b0;
        send(0, 32'hFFFF0000, 32'h1234ABCD, 3'b000);
        req0_A = 32'd7; req0_B = 32'd9; req0_control = 3'b010; req0_valid = 1'b1;
        req1_A = 32'd1; req1_B = 32'd2; req1_control = 3'b010; req1_valid = 1'b1;
        @(negedge clock);
        held = 32'h12340000;
        repeat (5) begin
            @(negedge clock);
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_out", {31'd0, resp_id, resp_out}, {31'd0, 1'b0, held});
            chk("bp_no_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        end
        step();
        resp_ready = 1'b1;
        step();
        @(negedge clock);
        chk("bp_resume", {62'd0, req0_ready, req1_ready}, 64'b01);
        step();
        req1_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (req0_ready) break;
        end
        step();
        req0_valid = 1'b0;
        repeat (4) step();

        // Reset in EXEC discards the op and restores req0 priority on a tie
        send(0, 32'd1, 32'd2, 3'b010);
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clock);
        chk("rexec_valid", {63'd0, resp_valid}, 64'd0);
        chk("rexec_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rexec_tie", {62'd0, req0_ready, req1_ready}, 64'b10);
        chk("rexec_idle_valid", {63'd0, resp_valid}, 64'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Reset in RESP drops resp_valid without waiting for a clock edge
        resp_ready = 1'b0;
        send(1, 32'd4, 32'd4, 3'b010);
        @(negedge clock);
        @(negedge clock);
        chk("rresp_pre", {63'd0, resp_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rresp_async", {63'd0, resp_valid}, 64'd0);
        step();
        reset = 1'b0;
        resp_ready = 1'b1;
        repeat (2) step();

        chk("sb_drain", {32'd0, exp_q.size()}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
